// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS core datapath: MemtoReg select, load types and
// the MEM/WB control bundle.
package mips_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_LINK = 2'b10,
    MTR_RSVD = 2'b11
  } memtoreg_e;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_H  = 3'd1,
    LD_HU = 3'd2,
    LD_B  = 3'd3,
    LD_BU = 3'd4
  } load_e;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] memtoreg;
    logic [2:0] load_type;
    logic [1:0] addr_lo;
    logic [4:0] write_reg;
  } wb_ctrl_t;
endpackage

// File: rtl/load_formatter.sv
// Big-endian load data extraction and extension with alignment check.
// Byte offset 0 is bits 31:24.
module load_formatter
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] mem_data,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_data[31:24];
    case (addr_lo)
      2'b00: byte_sel = mem_data[31:24];
      2'b01: byte_sel = mem_data[23:16];
      2'b10: byte_sel = mem_data[15:8];
      2'b11: byte_sel = mem_data[7:0];
      default: byte_sel = mem_data[31:24];
    endcase
    half_sel = addr_lo[1] ? mem_data[15:0] : mem_data[31:16];
  end

  // Unknown load types fall back to word loads, including the alignment rule.
  always_comb begin
    data       = mem_data;
    misaligned = 1'b0;
    case (load_type)
      LD_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU: data = {24'h0, byte_sel};
      LD_H: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      LD_HU: begin
        data       = {16'h0, half_sel};
        misaligned = addr_lo[0];
      end
      default: begin
        data       = mem_data;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback: drives the register file write
// port, the bypass copy, misaligned-load reporting and the retire counter.
module wb_stage
  import mips_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic                in_RegWrite,
  input  logic [1:0]          in_MemtoReg,
  input  logic [2:0]          in_load_type,
  input  logic [1:0]          in_addr_lo,
  input  logic [XLEN-1:0]     in_alu_result,
  input  logic [XLEN-1:0]     in_mem_data,
  input  logic [XLEN-1:0]     in_pc_plus8,
  input  logic [4:0]          in_write_reg,
  output logic                RegWrite,
  output logic [4:0]          write_reg,
  output logic [XLEN-1:0]     write_data,
  output logic                fwd_valid,
  output logic [4:0]          fwd_reg,
  output logic [XLEN-1:0]     fwd_data,
  output logic                misalign_err,
  output logic [RETIRE_W-1:0] retired_count
);
  wb_ctrl_t              ctrl_q, ctrl_d;
  logic [XLEN-1:0]       alu_q, alu_d, mem_q, mem_d, pc8_q, pc8_d;
  logic [RETIRE_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]       ld_data;
  logic                  ld_mis;
  logic                  mis;

  // Stall beats flush: a held stage must keep re-asserting its write.
  always_comb begin
    ctrl_d = ctrl_q;
    alu_d  = alu_q;
    mem_d  = mem_q;
    pc8_d  = pc8_q;
    if (!stall) begin
      if (flush) begin
        ctrl_d = '0;
        alu_d  = '0;
        mem_d  = '0;
        pc8_d  = '0;
      end else begin
        ctrl_d.valid     = in_valid;
        ctrl_d.reg_write = in_RegWrite;
        ctrl_d.memtoreg  = in_MemtoReg;
        ctrl_d.load_type = in_load_type;
        ctrl_d.addr_lo   = in_addr_lo;
        ctrl_d.write_reg = in_write_reg;
        alu_d            = in_alu_result;
        mem_d            = in_mem_data;
        pc8_d            = in_pc_plus8;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!stall && ctrl_q.valid) cnt_d = cnt_q + RETIRE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      alu_q  <= '0;
      mem_q  <= '0;
      pc8_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      alu_q  <= alu_d;
      mem_q  <= mem_d;
      pc8_q  <= pc8_d;
      cnt_q  <= cnt_d;
    end
  end

  load_formatter u_fmt (
    .mem_data  (mem_q),
    .addr_lo   (ctrl_q.addr_lo),
    .load_type (ctrl_q.load_type),
    .data      (ld_data),
    .misaligned(ld_mis)
  );

  assign mis = ctrl_q.valid && (ctrl_q.memtoreg == MTR_MEM) && ld_mis;

  always_comb begin
    case (ctrl_q.memtoreg)
      MTR_MEM:  write_data = ld_data;
      MTR_LINK: write_data = pc8_q;
      default:  write_data = alu_q;
    endcase
  end

  assign RegWrite      = ctrl_q.valid && ctrl_q.reg_write &&
                         (ctrl_q.write_reg != 5'd0) && !mis;
  assign write_reg     = ctrl_q.write_reg;
  assign misalign_err  = mis;
  assign fwd_valid     = RegWrite;
  assign fwd_reg       = write_reg;
  assign fwd_data      = write_data;
  assign retired_count = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// Scenario bench for wb_stage: expected writebacks are queued at drive time
// and popped once the stage presents them.
module tb_wb_stage;
  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid, in_RegWrite;
  logic [1:0]  in_MemtoReg, in_addr_lo;
  logic [2:0]  in_load_type;
  logic [31:0] in_alu_result, in_mem_data, in_pc_plus8;
  logic [4:0]  in_write_reg;
  logic        RegWrite, fwd_valid, misalign_err;
  logic [4:0]  write_reg, fwd_reg;
  logic [31:0] write_data, fwd_data, retired_count;

  int    errors = 0;
  int    checks = 0;
  exp_t  sb[$];
  logic  m_vld = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  wb_stage #(.XLEN(32), .RETIRE_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg),
    .in_load_type(in_load_type), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_pc_plus8(in_pc_plus8), .in_write_reg(in_write_reg),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .misalign_err(misalign_err), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Retire counter reference: counts a valid stage leaving on an unstalled edge.
  task automatic step();
    if (!rst_n) begin
      m_vld = 1'b0;
      m_cnt = 32'd0;
    end else if (!stall) begin
      if (m_vld) m_cnt = m_cnt + 32'd1;
      m_vld = flush ? 1'b0 : in_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] mtr,
                       input logic [2:0] lt, input logic [1:0] alo,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc8, input logic [4:0] wr);
    in_valid = v; in_RegWrite = rw; in_MemtoReg = mtr; in_load_type = lt;
    in_addr_lo = alo; in_alu_result = alu; in_mem_data = mem;
    in_pc_plus8 = pc8; in_write_reg = wr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 3'd0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; idle();
    e = '{1'b0, 5'd0, 32'h0, 1'b0};
    sb.push_back(e);
    step(); step();
    e = sb.pop_front();
    checks++;
    if ({RegWrite, write_reg, write_data, misalign_err, fwd_valid} !==
        {e.rw, e.wr, e.data, e.mis, e.rw} || retired_count !== m_cnt) begin
      errors++;
      $display("FAIL reset: rw=%0b wr=%0d data=%h mis=%0b cnt=%0d required all zero",
               RegWrite, write_reg, write_data, misalign_err, retired_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    exp_t e;
    drive(1'b1, 1'b1, 2'b00, 3'd0, 2'b00, 32'h16, 32'h0, 32'h0, 5'd10);
    sb.push_back('{1'b1, 5'd10, 32'h16, 1'b0});
    step();
    idle();
    e = sb.pop_front();
    checks++;
    if ({RegWrite, write_reg, write_data, misalign_err} !== {e.rw, e.wr, e.data, e.mis} ||
        {fwd_valid, fwd_reg, fwd_data} !== {e.rw, e.wr, e.data}) begin
      errors++;
      $display("FAIL alu_wb: got rw=%0b wr=%0d data=%h fwd=%0b/%0d/%h required rw=%0b wr=%0d data=%h",
               RegWrite, write_reg, write_data, fwd_valid, fwd_reg, fwd_data, e.rw, e.wr, e.data);
    end
    step();
    checks++;
    if (retired_count !== 32'd1 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL alu_retire: cnt=%0d rw=%0b required cnt=1 rw=0", retired_count, RegWrite);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  lt [5]  = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
    logic [1:0]  alo[5]  = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [31:0] res[5]  = '{32'hFFFFFF80, 32'h000000FF, 32'h00007F01, 32'h000080FF, 32'h80FF7F01};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'b01, lt[i], alo[i], 32'hA5A5A5A5, 32'h80FF7F01, 32'h0, 5'(i + 3));
      sb.push_back('{1'b1, 5'(i + 3), res[i], 1'b0});
      step();
      e = sb.pop_front();
      checks++;
      if ({RegWrite, write_reg, write_data, misalign_err} !== {e.rw, e.wr, e.data, e.mis}) begin
        errors++;
        $display("FAIL load_%0d: got rw=%0b wr=%0d data=%h mis=%0b required wr=%0d data=%h",
                 i, RegWrite, write_reg, write_data, misalign_err, e.wr, e.data);
      end
    end
    idle();
    step();
    checks++;
    if (retired_count !== m_cnt) begin
      errors++;
      $display("FAIL load_retire: cnt=%0d required %0d", retired_count, m_cnt);
    end
  endtask

  task automatic test_misalign();
    logic [2:0] lt [2] = '{3'd0, 3'd1};
    logic [1:0] alo[2] = '{2'b01, 2'b11};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 2'b01, lt[i], alo[i], 32'h0, 32'h12345678, 32'h0, 5'd9);
      sb.push_back('{1'b0, 5'd9, 32'h0, 1'b1});
      step();
      idle();
      e = sb.pop_front();
      checks++;
      if (RegWrite !== e.rw || misalign_err !== e.mis || fwd_valid !== e.rw) begin
        errors++;
        $display("FAIL misalign_%0d: rw=%0b mis=%0b required rw=0 mis=1", i, RegWrite, misalign_err);
      end
      step();
      checks++;
      if (misalign_err !== 1'b0 || retired_count !== m_cnt) begin
        errors++;
        $display("FAIL misalign_pulse_%0d: mis=%0b cnt=%0d required mis=0 cnt=%0d",
                 i, misalign_err, retired_count, m_cnt);
      end
    end
  endtask

  task automatic test_zero_and_link();
    exp_t e;
    drive(1'b1, 1'b1, 2'b00, 3'd0, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0);
    sb.push_back('{1'b0, 5'd0, 32'h0, 1'b0});
    step();
    e = sb.pop_front();
    checks++;
    if (RegWrite !== e.rw || fwd_valid !== e.rw) begin
      errors++;
      $display("FAIL zero_reg: rw=%0b fwd=%0b required 0", RegWrite, fwd_valid);
    end
    drive(1'b1, 1'b1, 2'b10, 3'd0, 2'b00, 32'h11111111, 32'h0, 32'h00400028, 5'd31);
    sb.push_back('{1'b1, 5'd31, 32'h00400028, 1'b0});
    step();
    idle();
    e = sb.pop_front();
    checks++;
    if ({RegWrite, write_reg, write_data} !== {e.rw, e.wr, e.data}) begin
      errors++;
      $display("FAIL link_wb: got rw=%0b wr=%0d data=%h required wr=31 data=%h",
               RegWrite, write_reg, write_data, e.data);
    end
  endtask

  task automatic test_stall_flush();
    exp_t e;
    drive(1'b1, 1'b1, 2'b00, 3'd0, 2'b00, 32'h00001234, 32'h0, 32'h0, 5'd7);
    e = '{1'b1, 5'd7, 32'h00001234, 1'b0};
    step();
    drive(1'b1, 1'b1, 2'b00, 3'd0, 2'b00, 32'hCAFEF00D, 32'h0, 32'h0, 5'd8);
    stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      flush = (c == 3);
      step();
      checks++;
      if ({RegWrite, write_reg, write_data} !== {e.rw, e.wr, e.data} || retired_count !== m_cnt) begin
        errors++;
        $display("FAIL stall_hold_%0d: got rw=%0b wr=%0d data=%h cnt=%0d required wr=7 data=%h cnt=%0d",
                 c, RegWrite, write_reg, write_data, retired_count, e.data, m_cnt);
      end
    end
    stall = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; idle();
    checks++;
    if (RegWrite !== 1'b0 || retired_count !== m_cnt) begin
      errors++;
      $display("FAIL flush: rw=%0b cnt=%0d required rw=0 cnt=%0d", RegWrite, retired_count, m_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 2'b00, 3'd0, 2'b00, 32'h100 * (i + 1), 32'h0, 32'h0, 5'(20 + i));
      sb.push_back('{1'b1, 5'(20 + i), 32'h100 * (i + 1), 1'b0});
      step();
      e = sb.pop_front();
      checks++;
      if ({RegWrite, write_reg, write_data} !== {e.rw, e.wr, e.data} || retired_count !== m_cnt) begin
        errors++;
        $display("FAIL b2b_%0d: got rw=%0b wr=%0d data=%h cnt=%0d required wr=%0d data=%h cnt=%0d",
                 i, RegWrite, write_reg, write_data, retired_count, e.wr, e.data, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 2'b00, 3'd0, 2'b00, 32'h55, 32'h0, 32'h0, 5'd12);
    rst_n = 1'b0; stall = 1'b1;
    step();
    checks++;
    if ({RegWrite, write_reg, write_data, misalign_err} !== 39'h0 || retired_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: rw=%0b wr=%0d data=%h cnt=%0d required all zero",
               RegWrite, write_reg, write_data, retired_count);
    end
    rst_n = 1'b1; stall = 1'b0; idle();
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_misalign();
    test_zero_and_link();
    test_stall_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
